// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end: MMU translation then one req/ack bus transaction
`ifndef MEM_ACCESS_T
`define MEM_ACCESS_T logic [1:0]
`define MEM_ACCESS_R 2'd0
`define MEM_ACCESS_W 2'd1
`define MEM_ACCESS_X 2'd2
`endif
`ifndef MMU_EXCEPTION_T
`define MMU_EXCEPTION_T logic [2:0]
`define MMU_EXCEPTION_NONE        3'd0
`define MMU_EXCEPTION_TLBMODIFIED 3'd1
`define MMU_EXCEPTION_TLBMISS     3'd2
`define MMU_EXCEPTION_ADDRERR     3'd3
`endif

module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 9
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_vaddr,
    input  `MEM_ACCESS_T          req_type,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_byteEn,
    input  logic                  flush,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_status,
    output `MMU_EXCEPTION_T       rsp_exception,
    output logic [31:0]           rsp_badVAddr,
    output logic                  mmu_addrValid,
    output logic [31:0]           mmu_vAddr,
    output `MEM_ACCESS_T          mmu_accessType,
    input  logic [31:0]           mmu_pAddr,
    input  `MMU_EXCEPTION_T       mmu_exception,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [31:0]           bus_wdata,
    output logic [3:0]            bus_byteEn,
    input  logic                  bus_ack,
    input  logic                  bus_err,
    input  logic [31:0]           bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BUS, S_RESP} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [31:0]          lat_vaddr;
    `MEM_ACCESS_T         lat_type;
    logic [31:0]          lat_wdata;
    logic [3:0]           lat_byte_en;
    logic                 drop;
    logic                 accept;
    logic                 mmu_fault;
    logic                 timed_out;
    logic                 silent;

    assign accept    = req_valid && req_ready;
    assign mmu_fault = (mmu_exception != `MMU_EXCEPTION_NONE);
    assign timed_out = (cnt == CNT_LAST);
    // A response is silenced by a flush seen earlier in BUS or by one arriving right now.
    assign silent    = drop || flush;

    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_CHECK;
            S_CHECK: begin
                if (flush)          state_nx = S_IDLE;
                else if (mmu_fault) state_nx = S_RESP;
                else                state_nx = S_BUS;
            end
            S_BUS:   if (bus_ack || bus_err || timed_out) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready      = res && (state == S_IDLE);
        mmu_addrValid  = req_ready && req_valid;
        mmu_vAddr      = req_ready ? req_vaddr : 32'd0;
        mmu_accessType = req_ready ? req_type : `MEM_ACCESS_R;
        bus_req        = (state == S_BUS);
        rsp_valid      = (state == S_RESP) && !silent;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt           <= '0;
            lat_vaddr     <= '0;
            lat_type      <= `MEM_ACCESS_R;
            lat_wdata     <= '0;
            lat_byte_en   <= '0;
            drop          <= 1'b0;
            rsp_rdata     <= '0;
            rsp_status    <= 2'd0;
            rsp_exception <= `MMU_EXCEPTION_NONE;
            rsp_badVAddr  <= '0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_byteEn    <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    lat_vaddr   <= req_vaddr;
                    lat_type    <= req_type;
                    lat_wdata   <= req_wdata;
                    lat_byte_en <= req_byteEn;
                    drop        <= 1'b0;
                end
                S_CHECK: if (!flush) begin
                    rsp_exception <= mmu_exception;
                    if (mmu_fault) begin
                        rsp_status   <= 2'd1;
                        rsp_badVAddr <= lat_vaddr;
                    end else begin
                        bus_addr   <= mmu_pAddr;
                        bus_we     <= (lat_type == `MEM_ACCESS_W);
                        bus_wdata  <= lat_wdata;
                        bus_byteEn <= lat_byte_en;
                        cnt        <= '0;
                    end
                end
                S_BUS: begin
                    if (flush) drop <= 1'b1;
                    if (bus_ack || bus_err || timed_out) begin
                        if (!silent) begin
                            rsp_badVAddr <= lat_vaddr;
                            if (bus_ack) begin
                                rsp_rdata  <= bus_rdata;
                                rsp_status <= 2'd0;
                            end else if (bus_err) begin
                                rsp_status <= 2'd2;
                            end else begin
                                rsp_status <= 2'd3;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
`ifndef MEM_ACCESS_T
`define MEM_ACCESS_T logic [1:0]
`define MEM_ACCESS_R 2'd0
`define MEM_ACCESS_W 2'd1
`define MEM_ACCESS_X 2'd2
`endif
`ifndef MMU_EXCEPTION_T
`define MMU_EXCEPTION_T logic [2:0]
`define MMU_EXCEPTION_NONE        3'd0
`define MMU_EXCEPTION_TLBMODIFIED 3'd1
`define MMU_EXCEPTION_TLBMISS     3'd2
`define MMU_EXCEPTION_ADDRERR     3'd3
`endif

module tb_mem_access_unit;

    logic              clk = 1'b0;
    logic              res = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_vaddr = '0;
    `MEM_ACCESS_T      req_type = `MEM_ACCESS_R;
    logic [31:0]       req_wdata = '0;
    logic [3:0]        req_byteEn = '0;
    logic              flush = 1'b0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_status;
    `MMU_EXCEPTION_T   rsp_exception;
    logic [31:0]       rsp_badVAddr;
    logic              mmu_addrValid;
    logic [31:0]       mmu_vAddr;
    `MEM_ACCESS_T      mmu_accessType;
    logic [31:0]       mmu_pAddr = '0;
    `MMU_EXCEPTION_T   mmu_exception = `MMU_EXCEPTION_NONE;
    logic              bus_req;
    logic              bus_we;
    logic [31:0]       bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_byteEn;
    logic              bus_ack = 1'b0;
    logic              bus_err = 1'b0;
    logic [31:0]       bus_rdata = '0;

    logic [31:0]       map_paddr = '0;
    `MMU_EXCEPTION_T   map_exc = `MMU_EXCEPTION_NONE;
    int                tests = 0;
    int                failed = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(9)) dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_type(req_type), .req_wdata(req_wdata), .req_byteEn(req_byteEn),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .rsp_exception(rsp_exception), .rsp_badVAddr(rsp_badVAddr),
        .mmu_addrValid(mmu_addrValid), .mmu_vAddr(mmu_vAddr), .mmu_accessType(mmu_accessType),
        .mmu_pAddr(mmu_pAddr), .mmu_exception(mmu_exception),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_byteEn(bus_byteEn), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // MMU stand-in: registers the translation on the edge after addrValid.
    always @(posedge clk) begin
        if (mmu_addrValid) begin
            mmu_pAddr     <= map_paddr;
            mmu_exception <= map_exc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Start of a new cycle: inputs return to idle defaults shortly after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        flush     = 1'b0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
    endtask

    // Cycle 0: present a request and check it is taken.
    task automatic issue(input logic [31:0] va, input logic [1:0] ty, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] pa, input logic [2:0] ex);
        cyc();
        req_valid  = 1'b1;
        req_vaddr  = va;
        req_type   = ty;
        req_wdata  = wd;
        req_byteEn = be;
        map_paddr  = pa;
        map_exc    = ex;
        #1;
        chk1("accept_ready", req_ready, 1'b1);
    endtask

    initial begin
        #3;
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_exception", 32'(rsp_exception), 32'(`MMU_EXCEPTION_NONE));
        cyc(); res = 1'b1; #1;
        chk1("post_rst_ready", req_ready, 1'b1);

        // Load, ack in cycle 4
        issue(32'h0040_1000, `MEM_ACCESS_R, 32'h0, 4'hF, 32'h0000_1000, `MMU_EXCEPTION_NONE);
        chk1("ld_mmu_valid", mmu_addrValid, 1'b1);
        chk("ld_mmu_vaddr", mmu_vAddr, 32'h0040_1000);
        cyc(); #1;
        chk1("ld_c1_ready", req_ready, 1'b0);
        chk1("ld_c1_bus_req", bus_req, 1'b0);
        chk1("ld_c1_mmu_valid", mmu_addrValid, 1'b0);
        cyc(); #1;
        chk1("ld_c2_bus_req", bus_req, 1'b1);
        chk("ld_bus_addr", bus_addr, 32'h0000_1000);
        chk1("ld_bus_we", bus_we, 1'b0);
        cyc(); #1;
        chk1("ld_c3_rsp_valid", rsp_valid, 1'b0);
        cyc(); bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
        chk1("ld_c4_bus_req", bus_req, 1'b1);
        cyc(); #1;
        chk1("ld_c5_rsp_valid", rsp_valid, 1'b1);
        chk("ld_status", 32'(rsp_status), 32'd0);
        chk("ld_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("ld_badvaddr", rsp_badVAddr, 32'h0040_1000);
        cyc(); #1;
        chk1("ld_c6_rsp_valid", rsp_valid, 1'b0);
        chk1("ld_c6_ready", req_ready, 1'b1);

        // Store hitting an MMU exception
        issue(32'h80, `MEM_ACCESS_W, 32'h1234_5678, 4'hF, 32'h0, `MMU_EXCEPTION_TLBMODIFIED);
        cyc(); #1;
        chk1("exc_c1_bus_req", bus_req, 1'b0);
        cyc(); #1;
        chk1("exc_c2_bus_req", bus_req, 1'b0);
        chk1("exc_c2_rsp_valid", rsp_valid, 1'b1);
        chk("exc_status", 32'(rsp_status), 32'd1);
        chk("exc_code", 32'(rsp_exception), 32'(`MMU_EXCEPTION_TLBMODIFIED));
        chk("exc_badvaddr", rsp_badVAddr, 32'h80);
        chk("exc_rdata_held", rsp_rdata, 32'hDEAD_BEEF);
        cyc(); #1;
        chk1("exc_c3_rsp_valid", rsp_valid, 1'b0);

        // No ack: timeout after 4 BUS cycles
        issue(32'h100, `MEM_ACCESS_R, 32'h0, 4'hF, 32'h200, `MMU_EXCEPTION_NONE);
        cyc();
        for (int c = 2; c <= 5; c++) begin
            cyc(); #1;
            chk1($sformatf("to_c%0d_bus_req", c), bus_req, 1'b1);
            chk1($sformatf("to_c%0d_rsp_valid", c), rsp_valid, 1'b0);
        end
        cyc(); #1;
        chk1("to_c6_bus_req", bus_req, 1'b0);
        chk1("to_c6_rsp_valid", rsp_valid, 1'b1);
        chk("to_status", 32'(rsp_status), 32'd3);
        chk("to_exception_none", 32'(rsp_exception), 32'(`MMU_EXCEPTION_NONE));

        // Ack on the last possible cycle beats the timeout
        issue(32'h104, `MEM_ACCESS_R, 32'h0, 4'hF, 32'h204, `MMU_EXCEPTION_NONE);
        cyc(); cyc(); cyc(); cyc();
        cyc(); bus_ack = 1'b1; bus_rdata = 32'hA5A5_A5A5;
        cyc(); #1;
        chk1("late_ack_rsp_valid", rsp_valid, 1'b1);
        chk("late_ack_status", 32'(rsp_status), 32'd0);
        chk("late_ack_rdata", rsp_rdata, 32'hA5A5_A5A5);

        // Store with bus error in cycle 3
        issue(32'h300, `MEM_ACCESS_W, 32'hCAFE_F00D, 4'h3, 32'h3000, `MMU_EXCEPTION_NONE);
        cyc();
        cyc(); #1;
        chk1("err_bus_we", bus_we, 1'b1);
        chk("err_bus_wdata", bus_wdata, 32'hCAFE_F00D);
        chk("err_bus_byteEn", 32'(bus_byteEn), 32'h3);
        chk("err_bus_addr", bus_addr, 32'h3000);
        cyc(); bus_err = 1'b1;
        cyc(); #1;
        chk1("err_c4_rsp_valid", rsp_valid, 1'b1);
        chk("err_status", 32'(rsp_status), 32'd2);
        chk("err_badvaddr", rsp_badVAddr, 32'h300);

        // Ack and err together: ack wins
        issue(32'h400, `MEM_ACCESS_R, 32'h0, 4'hF, 32'h4000, `MMU_EXCEPTION_NONE);
        cyc();
        cyc(); bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1122_3344;
        cyc(); #1;
        chk1("both_rsp_valid", rsp_valid, 1'b1);
        chk("both_status", 32'(rsp_status), 32'd0);
        chk("both_rdata", rsp_rdata, 32'h1122_3344);

        // Flush in CHECK
        issue(32'h500, `MEM_ACCESS_R, 32'h0, 4'hF, 32'h5000, `MMU_EXCEPTION_NONE);
        cyc(); flush = 1'b1;
        cyc(); #1;
        chk1("fchk_bus_req", bus_req, 1'b0);
        chk1("fchk_rsp_valid", rsp_valid, 1'b0);
        chk1("fchk_ready", req_ready, 1'b1);
        cyc(); #1;
        chk1("fchk_c3_bus_req", bus_req, 1'b0);
        chk1("fchk_c3_rsp_valid", rsp_valid, 1'b0);

        // Flush in BUS: transaction completes silently
        issue(32'h600, `MEM_ACCESS_R, 32'h0, 4'hF, 32'h6000, `MMU_EXCEPTION_NONE);
        cyc();
        cyc(); flush = 1'b1;
        cyc(); #1;
        chk1("fbus_c3_bus_req", bus_req, 1'b1);
        cyc(); bus_ack = 1'b1; bus_rdata = 32'h0000_0099;
        cyc(); #1;
        chk1("fbus_c5_rsp_valid", rsp_valid, 1'b0);
        chk("fbus_rdata_held", rsp_rdata, 32'h1122_3344);
        cyc(); #1;
        chk1("fbus_c6_ready", req_ready, 1'b1);
        chk1("fbus_c6_rsp_valid", rsp_valid, 1'b0);

        // Reset during BUS
        issue(32'h700, `MEM_ACCESS_R, 32'h0, 4'hF, 32'h7000, `MMU_EXCEPTION_NONE);
        cyc();
        cyc(); #1;
        chk1("rbus_bus_req", bus_req, 1'b1);
        res = 1'b0; #1;
        chk1("rbus_req_drop", bus_req, 1'b0);
        chk1("rbus_ready_in_reset", req_ready, 1'b0);
        chk("rbus_rdata_cleared", rsp_rdata, 32'h0);
        cyc(); res = 1'b1; #1;
        chk1("rbus_ready_after", req_ready, 1'b1);

        // Normal request after reset, presented together with a flush that IDLE ignores
        issue(32'h800, `MEM_ACCESS_R, 32'h0, 4'hF, 32'h8000, `MMU_EXCEPTION_NONE);
        flush = 1'b1;
        cyc();
        cyc(); bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA; #1;
        chk("post_addr", bus_addr, 32'h8000);
        chk1("post_bus_req", bus_req, 1'b1);
        cyc(); #1;
        chk1("post_rsp_valid", rsp_valid, 1'b1);
        chk("post_status", 32'(rsp_status), 32'd0);
        chk("post_rdata", rsp_rdata, 32'h5555_AAAA);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
